// File: rtl/add_sched_pkg.sv
// Shared types and sizing for the multi-precision add sequencer.
package add_sched_pkg;

  localparam int unsigned N_DEF    = 32;
  localparam int unsigned MAXW_DEF = 8;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef logic req_id_t;

  function automatic int unsigned cnt_width(input int unsigned words);
    return $clog2(words) + 1;
  endfunction

endpackage

// File: rtl/add_sched_rr_arb2.sv
// Two-way round-robin arbiter; pointer moves past the requester just served.
module rr_arb2
  import add_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  req_id_t    i_served,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= 1'b0;
    else if (i_upd) r_ptr <= ~i_served;
  end

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = r_ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/add_sched.sv
// Shares one external adder between two multi-word add streams, chaining the
// carry between words through a flop at one word per cycle.
module add_sched
  import add_sched_pkg::*;
#(
  parameter int unsigned n    = N_DEF,
  parameter int unsigned maxw = MAXW_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic         req0_cin,
  input  logic         req0_last,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic         req1_cin,
  input  logic         req1_last,
  output logic [n-1:0] add_a,
  output logic [n-1:0] add_b,
  output logic         add_cin,
  input  logic [n-1:0] add_s,
  input  logic         add_cout,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [n-1:0] rsp_s,
  output logic         rsp_cout,
  output logic         rsp_last,
  output logic         rsp_id,
  output logic         rsp_ovf
);

  localparam int unsigned CNT_W = cnt_width(maxw);

  state_t             r_state, w_state_nxt;
  req_id_t            r_gnt, w_gnt_nxt;
  logic [1:0]         w_arb_gnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_g_valid, w_g_cin, w_g_last;
  logic [n-1:0]       w_g_a, w_g_b;
  logic               w_adv, w_ready, w_acc, w_limit, w_last_eff, w_fire, w_end;

  logic               r_op_valid, r_op_first, r_op_cin, r_op_last, r_op_ovf;
  req_id_t            r_op_id;
  logic [n-1:0]       r_op_a, r_op_b;
  logic               r_carry;

  logic               r_rsp_valid, r_rsp_cout, r_rsp_last, r_rsp_ovf;
  req_id_t            r_rsp_id;
  logic [n-1:0]       r_rsp_s;

  always_comb begin
    w_g_valid = r_gnt ? req1_valid : req0_valid;
    w_g_a     = r_gnt ? req1_a     : req0_a;
    w_g_b     = r_gnt ? req1_b     : req0_b;
    w_g_cin   = r_gnt ? req1_cin   : req0_cin;
    w_g_last  = r_gnt ? req1_last  : req0_last;
  end

  assign w_adv      = !r_rsp_valid | rsp_ready;
  assign w_ready    = (r_state == BUSY) & (!r_op_valid | w_adv);
  assign w_acc      = w_ready & w_g_valid;
  assign w_limit    = (r_cnt == CNT_W'(maxw - 1));
  assign w_last_eff = w_g_last | w_limit;
  assign w_fire     = r_op_valid & w_adv;
  assign w_end      = w_acc & w_last_eff;

  assign req0_ready = w_ready & (r_gnt == 1'b0);
  assign req1_ready = w_ready & (r_gnt == 1'b1);

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    ({req1_valid, req0_valid}),
    .i_upd    (w_end),
    .i_served (r_gnt),
    .o_gnt    (w_arb_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      IDLE: if (w_arb_gnt != 2'b00) begin
        w_state_nxt = BUSY;
        w_gnt_nxt   = w_arb_gnt[1];
      end
      BUSY: if (w_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      if (w_acc) r_cnt <= w_last_eff ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Stage 1: operand register feeding the external adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_valid <= 1'b0;
      r_op_first <= 1'b0;
      r_op_cin   <= 1'b0;
      r_op_last  <= 1'b0;
      r_op_ovf   <= 1'b0;
      r_op_id    <= 1'b0;
      r_op_a     <= '0;
      r_op_b     <= '0;
    end else if (w_acc) begin
      r_op_valid <= 1'b1;
      r_op_first <= (r_cnt == '0);
      r_op_cin   <= w_g_cin;
      r_op_last  <= w_last_eff;
      r_op_ovf   <= w_limit & !w_g_last;
      r_op_id    <= r_gnt;
      r_op_a     <= w_g_a;
      r_op_b     <= w_g_b;
    end else if (w_fire) begin
      r_op_valid <= 1'b0;
    end
  end

  assign add_a   = r_op_a;
  assign add_b   = r_op_b;
  assign add_cin = r_op_first ? r_op_cin : r_carry;

  // Stage 2: response register; carry advances in lockstep with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_s     <= '0;
      r_rsp_cout  <= 1'b0;
      r_rsp_last  <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_ovf   <= 1'b0;
      r_carry     <= 1'b0;
    end else if (w_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_s     <= add_s;
      r_rsp_cout  <= r_op_last ? add_cout : 1'b0;
      r_rsp_last  <= r_op_last;
      r_rsp_id    <= r_op_id;
      r_rsp_ovf   <= r_op_ovf;
      r_carry     <= add_cout;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_s     = r_rsp_s;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_last  = r_rsp_last;
  assign rsp_id    = r_rsp_id;
  assign rsp_ovf   = r_rsp_ovf;

endmodule

// File: tb/tb_add_sched.sv
// Scoreboard bench for add_sched: drivers push golden multi-word sums, a
// monitor pops and compares each accepted response word.
module tb_add_sched;

  localparam int MAXW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req0_cin, req0_last;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin, req1_last;
  logic [31:0] req1_a, req1_b;
  logic [31:0] add_a, add_b, add_s;
  logic        add_cin, add_cout;
  logic        rsp_valid, rsp_ready, rsp_cout, rsp_last, rsp_id, rsp_ovf;
  logic [31:0] rsp_s;
  logic [32:0] w_sum;

  always #5 clk = ~clk;

  assign w_sum    = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);
  assign add_s    = w_sum[31:0];
  assign add_cout = w_sum[32];

  add_sched #(.n(32), .maxw(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_cin(req0_cin), .req0_last(req0_last),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_cin(req1_cin), .req1_last(req1_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_s(rsp_s), .rsp_cout(rsp_cout),
    .rsp_last(rsp_last), .rsp_id(rsp_id), .rsp_ovf(rsp_ovf)
  );

  typedef struct packed {
    logic [31:0] s;
    logic        cout;
    logic        last;
    logic        ovf;
  } exp_t;

  exp_t q0[$], q1[$];
  int   owner_q[$];
  int   n_pass = 0, n_tot = 0;
  int   acc_cnt[2] = '{0, 0};
  bit   mon_en = 1'b0, rdy_rand = 1'b0;
  logic rdy_force = 1'b1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic set_req(input int id, input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic last);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin; req0_last = last;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin; req1_last = last;
    end
  endtask

  // Golden: word-serial multi-precision add, restarted from cin every MAXW words
  task automatic drive_txn(input int id, input int len, input logic cin,
                           input logic [31:0] a[16], input logic [31:0] b[16]);
    logic        c, rdy;
    logic        cu[16];
    logic [32:0] sum;
    exp_t        e;
    int          cnt, tmo;
    c = 1'b0;
    cnt = 0;
    for (int i = 0; i < len; i++) begin
      if (cnt == 0) c = cin;
      cu[i]  = c;
      sum    = {1'b0, a[i]} + {1'b0, b[i]} + 33'(c);
      e.s    = sum[31:0];
      e.last = (i == len - 1) || (cnt == MAXW - 1);
      e.ovf  = e.last && (i != len - 1);
      e.cout = e.last ? sum[32] : 1'b0;
      c      = sum[32];
      cnt    = e.last ? 0 : cnt + 1;
      if (id == 0) q0.push_back(e); else q1.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      set_req(id, 1'b1, a[i], b[i], cin, i == len - 1);
      tmo = 0;
      rdy = 1'b0;
      while (!rdy && tmo < 2000) begin
        @(negedge clk);
        rdy = (id == 0) ? req0_ready : req1_ready;
        tmo++;
      end
      if (!rdy) begin
        n_tot++;
        $display("FAIL handshake_timeout: req%0d word %0d not accepted, got ready=0 expected 1", id, i);
        set_req(id, 1'b0, '0, '0, 1'b0, 1'b0);
        return;
      end
      @(posedge clk);
      #1;
      acc_cnt[id]++;
      check($sformatf("add_a req%0d w%0d", id, i), 64'(add_a), 64'(a[i]));
      check($sformatf("add_b req%0d w%0d", id, i), 64'(add_b), 64'(b[i]));
      check($sformatf("add_cin req%0d w%0d", id, i), 64'(add_cin), 64'(cu[i]));
    end
    set_req(id, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic rand_txn(input int id, input int len);
    logic [31:0] a[16], b[16];
    foreach (a[k]) begin
      a[k] = $urandom;
      b[k] = $urandom;
    end
    drive_txn(id, len, 1'($urandom_range(0, 1)), a, b);
  endtask

  task automatic wait_drain();
    int tmo = 0;
    while ((q0.size() != 0 || q1.size() != 0) && tmo < 5000) begin
      @(negedge clk);
      tmo++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_tot++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 rsp_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  initial begin
    exp_t  e, g;
    logic  cur_id = 1'b0;
    bit    in_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && rsp_valid && rsp_ready) begin
        g = {rsp_s, rsp_cout, rsp_last, rsp_ovf};
        if (in_txn) check("no_interleave", 64'(rsp_id), 64'(cur_id));
        if ((rsp_id == 1'b0 && q0.size() == 0) || (rsp_id == 1'b1 && q1.size() == 0)) begin
          n_tot++;
          $display("FAIL unexpected_rsp: got id %0d s %h, expected no response", rsp_id, rsp_s);
        end else begin
          e = (rsp_id == 1'b0) ? q0.pop_front() : q1.pop_front();
          check($sformatf("rsp id%0d", rsp_id), 64'(g), 64'(e));
        end
        if (rsp_last) begin
          owner_q.push_back(int'(rsp_id));
          in_txn = 1'b0;
        end else begin
          in_txn = 1'b1;
          cur_id = rsp_id;
        end
      end
    end
  end

  initial begin
    logic [31:0] a[16], b[16];
    logic [103:0] snap3;
    int          nacc, tmo, snap;
    bit          r;
    set_req(0, 1'b0, '0, '0, 1'b0, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ready", 64'({req0_ready, req1_ready}), 64'(0));
    check("reset_add_a", 64'(add_a), 64'(0));
    check("reset_add_b", 64'(add_b), 64'(0));
    check("reset_ctl", 64'({add_cin, rsp_valid, rsp_cout, rsp_last, rsp_id, rsp_ovf}), 64'(0));
    check("reset_rsp_s", 64'(rsp_s), 64'(0));
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // single-word FFFFFFFF + 1
    foreach (a[k]) begin a[k] = '0; b[k] = '0; end
    a[0] = 32'hFFFF_FFFF; b[0] = 32'h1;
    drive_txn(0, 1, 1'b0, a, b);
    wait_drain();

    // 96-bit add on requester 1
    foreach (a[k]) begin a[k] = '0; b[k] = '0; end
    a[0] = 32'hFFFF_FFFF; a[1] = 32'hFFFF_FFFF; b[0] = 32'h1;
    drive_txn(1, 3, 1'b0, a, b);
    wait_drain();

    // contention: pointer starts at requester 0 and alternates
    reset_pulse();
    owner_q.delete();
    fork
      begin rand_txn(0, $urandom_range(1, 6)); rand_txn(0, $urandom_range(1, 6)); end
      begin rand_txn(1, $urandom_range(1, 6)); rand_txn(1, $urandom_range(1, 6)); end
    join
    wait_drain();
    check("owner_count", 64'(owner_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < owner_q.size(); i++)
      check($sformatf("owner_%0d", i), 64'(owner_q[i]), 64'(i % 2));

    // backpressure mid 4-word stream
    acc_cnt[0] = 0;
    fork
      rand_txn(0, 4);
      begin
        tmo = 0;
        while (acc_cnt[0] < 1 && tmo < 200) begin @(negedge clk); tmo++; end
        rdy_force = 1'b0;
        @(posedge clk);
        #2;
        snap = acc_cnt[0];
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          if (k == 3) snap3 = {39'(0), add_a, add_b, add_cin};
          if (k > 3) begin
            check("stall_add_ab", 64'({add_a, add_b}), snap3[64:1]);
            check("stall_add_cin", 64'(add_cin), 64'(snap3[0]));
          end
        end
        check("stall_accepts_le2", 64'((acc_cnt[0] - snap) <= 2), 64'(1));
        rdy_force = 1'b1;
      end
    join
    wait_drain();

    // word limit: 10 words, forced split after 8
    foreach (a[k]) begin a[k] = $urandom; b[k] = $urandom; end
    a[7] = 32'hFFFF_FFFF; b[7] = 32'h1;
    drive_txn(0, 10, 1'b0, a, b);
    wait_drain();

    // reset after 2 of 4 words
    mon_en = 1'b0;
    nacc = 0;
    tmo = 0;
    set_req(0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
    while (nacc < 2 && tmo < 100) begin
      @(negedge clk);
      r = req0_ready;
      @(posedge clk);
      #1;
      if (r) begin
        nacc++;
        set_req(0, 1'b1, $urandom, $urandom, 1'b0, 1'b0);
      end
      tmo++;
    end
    check("mid_accepts", 64'(nacc), 64'(2));
    rst_n = 1'b0;
    #1;
    check("mid_rst_add_a", 64'(add_a), 64'(0));
    check("mid_rst_add_b", 64'(add_b), 64'(0));
    check("mid_rst_rsp_s", 64'(rsp_s), 64'(0));
    check("mid_rst_ctl", 64'({req0_ready, req1_ready, add_cin, rsp_valid, rsp_cout,
                             rsp_last, rsp_id, rsp_ovf}), 64'(0));
    set_req(0, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    foreach (a[k]) begin a[k] = '0; b[k] = '0; end
    a[0] = 32'd5; b[0] = 32'd7;
    drive_txn(0, 1, 1'b0, a, b);
    wait_drain();

    // randomized traffic with random consumer backpressure
    rdy_rand = 1'b1;
    fork
      for (int t = 0; t < 15; t++) begin
        rand_txn(0, $urandom_range(1, 10));
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      for (int t = 0; t < 15; t++) begin
        rand_txn(1, $urandom_range(1, 10));
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    join
    rdy_rand = 1'b0;
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
